// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared states, defaults and index-width helper for the RAM arbiter
package arbitro_pkg;

  typedef enum logic [1:0] {
    LIVRE     = 2'd0,
    CONCEDIDO = 2'd1,
    LIBERA    = 2'd2,
    EXPIRADO  = 2'd3
  } estado_t;

  localparam int N_REQ_PADRAO   = 4;
  localparam int TIMEOUT_PADRAO = 255;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arbitro_memoria_asteroides_seletor_prioridade.sv
// rtl/arbitro_memoria_asteroides_seletor_prioridade.sv - combinational search for the first requester from a start index
module seletor_prioridade
  import arbitro_pkg::*;
#(
  parameter int N_REQ = N_REQ_PADRAO,
  parameter int W     = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [W-1:0]     inicio,
  output logic [W-1:0]     vencedor,
  output logic             valido
);

  logic [W-1:0] idx;

  always_comb begin
    vencedor = '0;
    valido   = 1'b0;
    idx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = W'((int'(inicio) + i) % N_REQ);
      if (!valido && req[idx]) begin
        valido   = 1'b1;
        vencedor = idx;
      end
    end
  end

endmodule

// File: rtl/arbitro_memoria_asteroides.sv
// rtl/arbitro_memoria_asteroides.sv - single-port RAM arbiter with watchdog; ARBITRO_ROUND_ROBIN_EN selects rotating priority
module arbitro_memoria_asteroides
  import arbitro_pkg::*;
#(
  parameter int N_REQ   = N_REQ_PADRAO,
  parameter int TIMEOUT = TIMEOUT_PADRAO
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            fim_acesso,
  output logic [N_REQ-1:0]            grant,
  output logic [idx_width(N_REQ)-1:0] dono,
  output logic                        ocupado,
  output logic                        erro_timeout,
  output logic [1:0]                  db_estado
);

  localparam int W  = idx_width(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CONT_MAX = CW'(TIMEOUT - 1);

  estado_t          estado, estado_prox;
  logic [CW-1:0]    cont, cont_prox;
  logic [W-1:0]     dono_prox, inicio, vencedor;
  logic             valido;
  logic [N_REQ-1:0] grant_prox;

`ifdef ARBITRO_ROUND_ROBIN_EN
  // Pointer holds the last winner so the search starts just past it.
  logic [W-1:0] ponteiro;

  always_ff @(posedge clock) begin
    if (reset)
      ponteiro <= W'(N_REQ - 1);
    else if (estado == LIVRE && valido)
      ponteiro <= vencedor;
  end

  assign inicio = (ponteiro == W'(N_REQ - 1)) ? '0 : ponteiro + W'(1);
`else
  assign inicio = '0;
`endif

  seletor_prioridade #(.N_REQ(N_REQ), .W(W)) u_seletor (
    .req      (req),
    .inicio   (inicio),
    .vencedor (vencedor),
    .valido   (valido)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= LIVRE;
      cont   <= '0;
      dono   <= '0;
      grant  <= '0;
    end else begin
      estado <= estado_prox;
      cont   <= cont_prox;
      dono   <= dono_prox;
      grant  <= grant_prox;
    end
  end

  always_comb begin
    estado_prox = estado;
    dono_prox   = dono;
    cont_prox   = '0;
    case (estado)
      LIVRE: begin
        if (valido) begin
          estado_prox = CONCEDIDO;
          dono_prox   = vencedor;
        end
      end
      CONCEDIDO: begin
        // Release takes precedence over a simultaneous timeout.
        if (fim_acesso[dono])
          estado_prox = LIBERA;
        else if (cont == CONT_MAX)
          estado_prox = EXPIRADO;
        else
          cont_prox = cont + CW'(1);
      end
      LIBERA:   estado_prox = LIVRE;
      EXPIRADO: estado_prox = LIVRE;
      default:  estado_prox = LIVRE;
    endcase
    grant_prox = (estado_prox == CONCEDIDO) ? (N_REQ'(1) << dono_prox) : '0;
  end

  assign ocupado      = (estado == CONCEDIDO);
  assign erro_timeout = (estado == EXPIRADO);
  assign db_estado    = estado;

endmodule

// File: tb/tb_arbitro_memoria_asteroides.sv
// tb/tb_arbitro_memoria_asteroides.sv - self-checking bench for arbitro_memoria_asteroides (TIMEOUT=4)
module tb_arbitro_memoria_asteroides;

  localparam int N = 4;
  localparam int T = 4;

  logic         clock;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] fim_acesso;
  logic [N-1:0] grant;
  logic [1:0]   dono;
  logic         ocupado;
  logic         erro_timeout;
  logic [1:0]   db_estado;

  int checks   = 0;
  int failures = 0;

  arbitro_memoria_asteroides #(.N_REQ(N), .TIMEOUT(T)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .fim_acesso   (fim_acesso),
    .grant        (grant),
    .dono         (dono),
    .ocupado      (ocupado),
    .erro_timeout (erro_timeout),
    .db_estado    (db_estado)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nome, atual, esperado, $time);
    end
  endtask

  // Reference model: who owns the RAM, how long it has held it, and the forced idle gap.
  int m_owner = -1;
  int m_held  = 0;
  int m_cool  = 0;
  int m_last  = 0;
  int m_ptr   = N - 1;
  int m_est   = 0;
  bit m_err   = 0;
  bit m_ok    = 0;

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    int start;
`ifdef ARBITRO_ROUND_ROBIN_EN
    start = (ptr + 1) % N;
`else
    start = 0;
`endif
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  always @(posedge clock) begin
    int w;
    if (reset) begin
      m_owner = -1; m_held = 0; m_cool = 0; m_err = 0;
      m_last = 0; m_ptr = N - 1; m_est = 0; m_ok = 1;
    end else if (m_ok) begin
      m_err = 0;
      if (m_owner >= 0) begin
        if (fim_acesso[m_owner]) begin
          m_owner = -1; m_cool = 1; m_est = 2;
        end else if (m_held == T) begin
          m_owner = -1; m_cool = 1; m_est = 3; m_err = 1;
        end else begin
          m_held++;
        end
      end else if (m_cool > 0) begin
        m_cool--;
        m_est = 0;
      end else begin
        m_est = 0;
        w = pick(req, m_ptr);
        if (w >= 0) begin
          m_owner = w; m_last = w; m_ptr = w; m_held = 1; m_est = 1;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (m_ok) begin
      chk("model_grant", 32'(grant), (m_owner >= 0) ? 32'(1) << m_owner : 32'd0);
      chk("model_dono", 32'(dono), 32'(m_last));
      chk("model_ocupado", 32'(ocupado), 32'(m_owner >= 0));
      chk("model_erro", 32'(erro_timeout), 32'(m_err));
      chk("model_estado", 32'(db_estado), 32'(m_est));
    end
  end

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] f);
    req        = r;
    fim_acesso = f;
    @(negedge clock);
  endtask

`ifdef ARBITRO_ROUND_ROBIN_EN
  localparam logic [N-1:0] T2_G2 = 4'b1000;
  localparam logic [1:0]   T2_D2 = 2'd3;
`else
  localparam logic [N-1:0] T2_G2 = 4'b0010;
  localparam logic [1:0]   T2_D2 = 2'd1;
`endif

  initial begin
    logic [N-1:0] f;
    reset = 1'b1; req = '0; fim_acesso = '0;
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000);
    reset = 1'b0;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_dono", 32'(dono), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_erro", 32'(erro_timeout), 32'd0);
    chk("rst_estado", 32'(db_estado), 32'd0);

    // T1 single owner
    cyc(4'b0001, 4'b0000);
    chk("t1_grant", 32'(grant), 32'h1);
    chk("t1_ocupado", 32'(ocupado), 32'd1);
    cyc(4'b0000, 4'b0001);
    chk("t1_rel_grant", 32'(grant), 32'h0);
    chk("t1_rel_estado", 32'(db_estado), 32'd2);
    cyc(4'b0000, 4'b0000);
    chk("t1_livre", 32'(db_estado), 32'd0);

    // T2 simultaneous requests
    cyc(4'b1010, 4'b0000);
    chk("t2_grant1", 32'(grant), 32'h2);
    chk("t2_dono1", 32'(dono), 32'd1);
    cyc(4'b1010, 4'b0010);
    cyc(4'b1010, 4'b0000);
    chk("t2_gap", 32'(grant), 32'h0);
    cyc(4'b1010, 4'b0000);
    chk("t2_grant2", 32'(grant), 32'(T2_G2));
    chk("t2_dono2", 32'(dono), 32'(T2_D2));
    cyc(4'b0000, T2_G2);
    cyc(4'b0000, 4'b0000);

    // T3 timeout: grant high exactly T cycles
    cyc(4'b0100, 4'b0000);
    chk("t3_grant_c1", 32'(grant), 32'h4);
    for (int i = 2; i <= T; i++) begin
      cyc(4'b0000, 4'b0000);
      chk("t3_grant_held", 32'(grant), 32'h4);
    end
    cyc(4'b0000, 4'b0000);
    chk("t3_exp_grant", 32'(grant), 32'h0);
    chk("t3_exp_erro", 32'(erro_timeout), 32'd1);
    chk("t3_exp_estado", 32'(db_estado), 32'd3);
    cyc(4'b0000, 4'b0000);
    chk("t3_erro_pulse", 32'(erro_timeout), 32'd0);
    chk("t3_livre", 32'(db_estado), 32'd0);

    // T4 release on the last allowed cycle wins over timeout
    cyc(4'b0001, 4'b0000);
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0000);
    chk("t4_still_granted", 32'(grant), 32'h1);
    cyc(4'b0000, 4'b0001);
    chk("t4_estado", 32'(db_estado), 32'd2);
    chk("t4_erro", 32'(erro_timeout), 32'd0);
    cyc(4'b0000, 4'b0000);

    // T5 foreign release ignored, dropping req does not release
    cyc(4'b0100, 4'b0000);
    cyc(4'b0000, 4'b0001);
    chk("t5_grant", 32'(grant), 32'h4);
    chk("t5_estado", 32'(db_estado), 32'd1);
    cyc(4'b0000, 4'b0100);
    cyc(4'b0000, 4'b0000);

    // T6 reset mid-grant
    cyc(4'b0010, 4'b0000);
    reset = 1'b1;
    req   = '0;
    #1;
    chk("t6_pre_grant", 32'(grant), 32'h2);
    @(negedge clock);
    chk("t6_grant", 32'(grant), 32'h0);
    chk("t6_ocupado", 32'(ocupado), 32'd0);
    chk("t6_estado", 32'(db_estado), 32'd0);
    chk("t6_dono", 32'(dono), 32'd0);
    reset = 1'b0;

    // All requesters contending, stray releases in LIBERA/LIVRE
    cyc(4'b1111, 4'b0000);
    for (int r = 0; r < 4; r++) begin
      f = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      cyc(4'b1111, f);
      cyc(4'b1111, 4'b1111);
      cyc(4'b1111, 4'b0000);
    end
    cyc(4'b0000, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
